dijkstra_ci_engine: RTL
=======================

// Module: dijkstra_ci_engine
// PURPOSE
// - Parametrised successor to our single-cycle Dijkstra custom instruction: Nios II multi-cycle
//   custom instruction (start/done) holding the distance, predecessor and visited tables on-chip.
// - Software issues INIT / RELAX / EXTRACT_MIN / READ_DIST / READ_PREV via n; CPU keeps edge walk.
// - Sits on the Nios custom-instruction slave port.
// PARAMETERS
// - DEPTH   64  number of graph nodes held (>=2)
// - DIST_W  16  distance width (<=32); all-ones (INF) = unreached
// - IDX_W   $clog2(DEPTH)  node index width (<=16), derived, not overridden
// PORTS
// - clk     in   1   single clock
// - reset   in   1   reset is asynchronous and active-low
// - clk_en  in   1   Nios clock enable; low = every register holds (done/result included)
// - start   in   1   1-cycle request; n/dataa/datab captured this cycle
// - n       in   3   opcode: 0 INIT,1 RELAX,2 EXTRACT_MIN,3 READ_DIST,4 READ_PREV,5-7 NOP
// - dataa   in   32  INIT: src; RELAX: [15:0] node v,[31:16] pred u; READ_*: node
// - datab   in   32  RELAX: candidate distance (low DIST_W bits used)
// - done    out  1   1-cycle pulse; result valid this cycle only
// - result  out  32  opcode result, zero-extended
// BEHAVIOUR
// - Reset: FSM=IDLE, done=0, result=0, visited=all 1s (EXTRACT/RELAX are no-ops until INIT);
//   dist/prev contents undefined. Reset mid-operation aborts it; no done is produced.
// - FSM: IDLE -> {CLEAR|RD|SCAN} -> RESP -> IDLE. start only accepted in IDLE; start while
//   busy is ignored (no second done). Cycle counts below assume clk_en=1, start at cycle 0.
// - INIT: CLEAR sweeps i=0..DEPTH-1: dist[i]=INF, prev[i]=i, visited[i]=0; then dist[src]=0.
//   done at cycle DEPTH+1, result=0. src>=DEPTH: tables cleared, no source, result=1.
// - RELAX: cycle 1 read dist[v]; cycle 2 compare/write. Update iff v<DEPTH, !visited[v],
//   cand!=INF, cand<dist[v] (unsigned): dist[v]=cand, prev[v]=u. done cycle 2; result=1 if
//   updated else 0. u not range-checked.
// - EXTRACT_MIN: SCAN reads i=0..DEPTH-1 (1/cycle, 1-cycle RAM latency), keeps min over
//   !visited and dist!=INF; ties -> lowest index. done cycle DEPTH+2. Found: visited[k]=1 in
//   the done cycle, result={dist[k][15:0],k[15:0]} (upper half saturates to 16'hFFFF if dist
//   >16'hFFFE). None found: result=32'hFFFF_FFFF, visited unchanged.
// - READ_DIST/READ_PREV: done cycle 2, result=dist[node]/prev[node]; node>=DEPTH ->
//   32'hFFFF_FFFF.
// - NOP opcodes 5-7: done cycle 1, result=0, no state change.
// - clk_en low stretches every latency by the stalled cycles; a start with clk_en low is ignored.
// - result holds last value between dones; software must sample only on done.
// STRUCTURE
// - dijkstra_pkg: opcode_e, state_e, function dist_inf(DIST_W), RESULT_NONE=32'hFFFF_FFFF.
// - Sub-module dijkstra_dist_ram: dist+prev arrays, 1 write / 1 sync read port, inferable as
//   M10K. visited stays a flop vector in the engine (needs parallel clear).
// TESTING (DEPTH=8, DIST_W=16)
// - Reset then EXTRACT_MIN -> done at +10, result=FFFF_FFFF; RELAX v=3 cand=5 -> result=0.
// - INIT src=2 -> done at +9; READ_DIST 2 -> 0; READ_DIST 5 -> 0000_FFFF; READ_PREV 5 -> 5.
// - RELAX v=4 u=2 cand=7 -> 1; cand=9 -> 0; cand=7 -> 0 (equal); READ_PREV 4 -> 2.
// - After INIT src=2 and dist[4]=7,dist[6]=7: EXTRACT x4 -> 0000_0002,0007_0004,0007_0006,
//   FFFF_FFFF; RELAX v=4 cand=1 -> 0 (visited).
// - start pulsed again at +3 during INIT -> exactly one done; clk_en low for 4 cycles
//   mid-SCAN -> done delayed exactly 4, same result.
// - Assert reset at cycle 3 of EXTRACT -> done=0,result=0 async; no done after release;
//   READ_DIST 9 -> FFFF_FFFF; n=6 -> done at +1, result=0.

Source files
------------

// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra custom-instruction engine.
package dijkstra_pkg;

  typedef enum logic [2:0] {
    OP_INIT    = 3'd0,
    OP_RELAX   = 3'd1,
    OP_EXTRACT = 3'd2,
    OP_RDIST   = 3'd3,
    OP_RPREV   = 3'd4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RD    = 3'd2,
    ST_SCAN  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [31:0] RESULT_NONE = 32'hFFFF_FFFF;
  localparam int PREV_W = 16;

  // All-ones pattern of the given width marks an unreached node
  function automatic logic [31:0] dist_inf(input int unsigned w);
    logic [31:0] m;
    if (w < 32'd32) begin
      m = ~(32'hFFFF_FFFF << w);
    end else begin
      m = 32'hFFFF_FFFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/dijkstra_dist_ram.sv
// Distance and predecessor tables: one write port, one registered read port.
module dijkstra_dist_ram
  import dijkstra_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DIST_W = 16
) (
  input  logic                     clk,
  input  logic                     clk_en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DIST_W-1:0]        wdist,
  input  logic [PREV_W-1:0]        wprev,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DIST_W-1:0]        rdist,
  output logic [PREV_W-1:0]        rprev
);

  logic [DIST_W-1:0] dist_mem_r [DEPTH];
  logic [PREV_W-1:0] prev_mem_r [DEPTH];

  // Table write and synchronous read; unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (we) begin
        dist_mem_r[waddr] <= wdist;
        prev_mem_r[waddr] <= wprev;
      end
      rdist <= dist_mem_r[raddr];
      rprev <= prev_mem_r[raddr];
    end
  end

endmodule

// File: rtl/dijkstra_ci_engine.sv
// Multi-cycle Nios II custom instruction holding Dijkstra dist/prev/visited tables.
module dijkstra_ci_engine
  import dijkstra_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DIST_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [2:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = IDX_W + 1;
  localparam logic [DIST_W-1:0] INF = DIST_W'(dist_inf(DIST_W));

  state_e              state_r, state_nxt_s;
  opcode_e             op_r;
  logic [IDX_W-1:0]    idx_r, cmp_idx_s, new_idx_s, best_idx_r;
  logic [15:0]         u_r, sat_dist_s;
  logic [DIST_W-1:0]   cand_r, rdist_s, new_dist_s, best_dist_r;
  logic [PREV_W-1:0]   rprev_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [DEPTH-1:0]    visited_r;
  logic [31:0]         result_r, result_s, ext_dist_s;
  logic                done_r, done_s, oor_r, oor_s, accept_s;
  logic                found_r, new_found_s, take_s, upd_s, visit_set_s;
  logic                we_s;
  logic [IDX_W-1:0]    waddr_s, raddr_s;
  logic [DIST_W-1:0]   wdist_s;
  logic [PREV_W-1:0]   wprev_s;
  logic                unused_s;

  // Candidate bits above DIST_W are ignored by design
  assign unused_s = ^datab;
  assign accept_s = (state_r == ST_IDLE) && start;
  assign oor_s    = (n == OP_RELAX) ? ({16'd0, dataa[15:0]} >= 32'(DEPTH))
                                    : (dataa >= 32'(DEPTH));
  assign done     = done_r;
  assign result   = result_r;

  dijkstra_dist_ram #(.DEPTH(DEPTH), .DIST_W(DIST_W)) u_ram (
    .clk(clk), .clk_en(clk_en), .we(we_s), .waddr(waddr_s), .wdist(wdist_s),
    .wprev(wprev_s), .raddr(raddr_s), .rdist(rdist_s), .rprev(rprev_s)
  );

  // Running minimum over the scan; RAM data lags the issued index by one cycle
  always_comb begin
    cmp_idx_s = cnt_r[IDX_W-1:0] - IDX_W'(1);
    take_s    = 1'b0;
    if ((state_r == ST_SCAN) && (cnt_r != CW'(0))) begin
      take_s = !visited_r[cmp_idx_s] && (rdist_s != INF) &&
               (!found_r || (rdist_s < best_dist_r));
    end else begin
      take_s = 1'b0;
    end
    if (take_s) begin
      new_found_s = 1'b1;
      new_dist_s  = rdist_s;
      new_idx_s   = cmp_idx_s;
    end else begin
      new_found_s = found_r;
      new_dist_s  = best_dist_r;
      new_idx_s   = best_idx_r;
    end
    ext_dist_s = 32'(new_dist_s);
    if (ext_dist_s > 32'h0000_FFFE) begin
      sat_dist_s = 16'hFFFF;
    end else begin
      sat_dist_s = ext_dist_s[15:0];
    end
  end

  // Next state, RAM control and response formation
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_s      = 1'b0;
    result_s    = 32'd0;
    we_s        = 1'b0;
    waddr_s     = idx_r;
    wdist_s     = cand_r;
    wprev_s     = u_r;
    raddr_s     = dataa[IDX_W-1:0];
    upd_s       = 1'b0;
    visit_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt_s = CW'(0);
          case (n)
            OP_INIT:                    state_nxt_s = ST_CLEAR;
            OP_RELAX, OP_RDIST, OP_RPREV: state_nxt_s = ST_RD;
            OP_EXTRACT:                 state_nxt_s = ST_SCAN;
            default: begin
              state_nxt_s = ST_RESP;
              done_s      = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // The source slot is written with zero during the sweep itself
        we_s      = 1'b1;
        waddr_s   = cnt_r[IDX_W-1:0];
        wprev_s   = PREV_W'(cnt_r[IDX_W-1:0]);
        cnt_nxt_s = cnt_r + CW'(1);
        if (!oor_r && (cnt_r[IDX_W-1:0] == idx_r)) begin
          wdist_s = '0;
        end else begin
          wdist_s = INF;
        end
        if (cnt_r == CW'(DEPTH - 1)) begin
          state_nxt_s = ST_RESP;
          done_s      = 1'b1;
          result_s    = {31'd0, oor_r};
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RD: begin
        state_nxt_s = ST_RESP;
        done_s      = 1'b1;
        case (op_r)
          OP_RELAX: begin
            upd_s    = !oor_r && !visited_r[idx_r] && (cand_r != INF) && (cand_r < rdist_s);
            we_s     = upd_s;
            result_s = {31'd0, upd_s};
          end
          OP_RDIST: result_s = oor_r ? RESULT_NONE : 32'(rdist_s);
          OP_RPREV: result_s = oor_r ? RESULT_NONE : 32'(rprev_s);
          default:  result_s = 32'd0;
        endcase
      end
      ST_SCAN: begin
        raddr_s   = cnt_r[IDX_W-1:0];
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(DEPTH)) begin
          state_nxt_s = ST_RESP;
          done_s      = 1'b1;
          visit_set_s = new_found_s;
          if (new_found_s) begin
            result_s = {sat_dist_s, 16'(new_idx_s)};
          end else begin
            result_s = RESULT_NONE;
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, capture, visited and output registers; all hold while clk_en is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_INIT;
      done_r      <= 1'b0;
      result_r    <= 32'd0;
      visited_r   <= '1;
      cnt_r       <= '0;
      idx_r       <= '0;
      u_r         <= 16'd0;
      cand_r      <= '0;
      oor_r       <= 1'b0;
      found_r     <= 1'b0;
      best_dist_r <= '0;
      best_idx_r  <= '0;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
      done_r  <= done_s;
      cnt_r   <= cnt_nxt_s;
      if (done_s) begin
        result_r <= result_s;
      end
      if (accept_s) begin
        op_r    <= opcode_e'(n);
        idx_r   <= dataa[IDX_W-1:0];
        u_r     <= dataa[31:16];
        cand_r  <= datab[DIST_W-1:0];
        oor_r   <= oor_s;
        found_r <= 1'b0;
        if (n == OP_INIT) begin
          visited_r <= '0;
        end
      end else if (state_r == ST_SCAN) begin
        found_r     <= new_found_s;
        best_dist_r <= new_dist_s;
        best_idx_r  <= new_idx_s;
        if (visit_set_s) begin
          visited_r[new_idx_s] <= 1'b1;
        end
      end
    end
  end

endmodule
